// File: rtl/deser_pkg.sv
// Shared types and constants for the serial deserializer and its parity helper.
package deser_pkg;

    localparam int DATA_WIDTH_DEFAULT = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } deser_state_e;

endpackage

// File: rtl/parity_calc.sv
// Expected parity bit for a received word: XOR of the data, inverted for odd parity.
module parity_calc
    import deser_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  par_typ_i,
    output logic                  par_bit_o
);

    assign par_bit_o = (^data_i) ^ (par_typ_i == PAR_ODD);

endmodule

// File: rtl/deserializer.sv
// Serial-to-parallel receiver: start(0), DATA_WIDTH bits LSB-first, optional parity, stop(1).
// Define PARITY_CHECK_EN to build the PARITY state and par_err; otherwise parity is ignored.
module deserializer
    import deser_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  deser_en,
    input  logic                  bit_tick,
    input  logic                  ser_in,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stop_err,
    output logic                  busy
);

    localparam int               CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    deser_state_e          state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  stop_err_q, stop_err_d;
    logic                  par_mis;

`ifdef PARITY_CHECK_EN
    logic par_en_q, par_en_d;
    logic par_typ_q, par_typ_d;
    logic par_mis_q, par_mis_d;
    logic par_err_q, par_err_d;
    logic par_exp;

    parity_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity_calc (
        .data_i   (shift_q),
        .par_typ_i(par_typ_q),
        .par_bit_o(par_exp)
    );

    assign par_mis = par_mis_q;
    assign par_err = par_err_q;
`else
    logic unused_par_cfg;
    assign unused_par_cfg = PAR_EN ^ PAR_TYP;
    assign par_mis        = 1'b0;
    assign par_err        = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets its default before the case so no path leaves it unassigned (no latches).
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        stop_err_d   = 1'b0;
`ifdef PARITY_CHECK_EN
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        par_mis_d    = par_mis_q;
        par_err_d    = 1'b0;
`endif

        if (!deser_en) begin
            state_d   = IDLE;
            cnt_d     = '0;
`ifdef PARITY_CHECK_EN
            par_mis_d = 1'b0;
`endif
        end else if (bit_tick) begin
            case (state_q)
                IDLE: begin
                    if (!ser_in) begin
                        state_d   = DATA;
                        cnt_d     = '0;
`ifdef PARITY_CHECK_EN
                        par_en_d  = PAR_EN;
                        par_typ_d = PAR_TYP;
                        par_mis_d = 1'b0;
`endif
                    end
                end
                DATA: begin
                    shift_d = {ser_in, shift_q[DATA_WIDTH-1:1]};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
                        state_d = par_en_q ? PARITY : STOP;
`else
                        state_d = STOP;
`endif
                    end
                end
                PARITY: begin
`ifdef PARITY_CHECK_EN
                    par_mis_d = (ser_in != par_exp);
`endif
                    state_d = STOP;
                end
                STOP: begin
                    state_d    = IDLE;
                    stop_err_d = ~ser_in;
`ifdef PARITY_CHECK_EN
                    par_err_d  = par_mis_q;
                    par_mis_d  = 1'b0;
`endif
                    // A word is published only when both framing and parity are clean.
                    if (ser_in && !par_mis) begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            stop_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            stop_err_q   <= stop_err_d;
        end
    end

`ifdef PARITY_CHECK_EN
    always_ff @(posedge CLK) begin
        if (rst) begin
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
            par_mis_q <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            par_mis_q <= par_mis_d;
            par_err_q <= par_err_d;
        end
    end
`endif

    assign P_DATA     = p_data_q;
    assign data_valid = data_valid_q;
    assign stop_err   = stop_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the number of data bits per frame.
REQ-002 SHALL have port CLK  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port deser_en  input  1  receive enable; low forces and holds IDLE.
REQ-005 SHALL have port bit_tick  input  1  one-cycle strobe marking the sample point of each serial bit.
REQ-006 SHALL have port ser_in  input  1  serial line; idle high; frame is start(0), data LSB-first, optional parity, stop(1).
REQ-007 SHALL have port PAR_EN  input  1  parity bit present in the frame (used only when PARITY_CHECK_EN is defined).
REQ-008 SHALL have port PAR_TYP  input  1  0 = even, 1 = odd (used only when PARITY_CHECK_EN is defined).
REQ-009 SHALL have port P_DATA  output  DATA_WIDTH  last good received word.
REQ-010 SHALL have port data_valid  output  1  one-cycle pulse when P_DATA is updated.
REQ-011 SHALL have port par_err  output  1  one-cycle pulse on parity mismatch.
REQ-012 SHALL have port stop_err  output  1  one-cycle pulse when the sampled stop bit is 0.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, DATA, PARITY and STOP; state and bit counter advance only in cycles where bit_tick=1 and deser_en=1.
REQ-015 IDLE SHALL move to DATA when bit_tick samples ser_in=0 (start bit); with ser_in=1 it SHALL stay in IDLE.
REQ-016 DATA SHALL shift ser_in into the MSB of a shift register on each tick, right-shifting so the first received bit ends in bit 0.
REQ-017 DATA SHALL leave after exactly DATA_WIDTH ticks, counted by a counter of width clog2(DATA_WIDTH+1) cleared on DATA entry; it goes to PARITY if parity is active, else to STOP.
REQ-018 PARITY SHALL compare ser_in with the XOR of the shift register (inverted when PAR_TYP=1), latch the mismatch flag and move to STOP.
REQ-019 STOP SHALL always return to IDLE on its tick.
  - ser_in=1 and no parity mismatch: P_DATA loaded, data_valid pulsed.
  - ser_in=0: stop_err pulsed, P_DATA held.
  - Parity mismatch: par_err pulsed, P_DATA held.
  - Both errors: both pulses in the same cycle.
REQ-020 data_valid, par_err and stop_err SHALL assert in the cycle after the STOP-sampling tick edge and last exactly one cycle.
REQ-021 The STOP tick SHALL be followed by IDLE; a start bit on the next tick SHALL be accepted, giving back-to-back frames with no gap.
REQ-022 deser_en=0 in any state SHALL, on the next edge, force IDLE, clear the counter and parity flag, suppress pulses and keep P_DATA.
REQ-023 bit_tick=0 cycles SHALL not change state, counter or shift register.
REQ-024 PAR_EN and PAR_TYP SHALL be sampled at DATA entry and held for the frame; mid-frame changes SHALL be ignored.

Reset
REQ-025 rst=1 at a rising CLK edge SHALL set state=IDLE, counter=0, shift register=0, P_DATA=0, data_valid=0, par_err=0, stop_err=0 and busy=0, overriding deser_en and bit_tick, including mid-frame.
REQ-026 The first frame after reset release SHALL need a fresh start bit; no partial frame SHALL be resumed.

Configuration
REQ-027 Macro PARITY_CHECK_EN SHALL control parity.
  - Defined: PARITY state and par_err logic are present, driven by PAR_EN and PAR_TYP.
  - Undefined: PARITY is never entered (DATA goes to STOP), PAR_EN and PAR_TYP are ignored, par_err is tied 0.

Structure
REQ-028 Package deser_pkg SHALL hold the state enum typedef (IDLE, DATA, PARITY, STOP), PAR_EVEN/PAR_ODD constants and the DATA_WIDTH default.
REQ-029 Parity computation SHALL live in sub-module parity_calc (data in, PAR_TYP in, expected bit out), instantiated only under PARITY_CHECK_EN.

Verification
REQ-030 Bench SHALL cover these directed scenarios:
  - No parity: frame 0, 0xA5 LSB-first, 1 with ticks every 16 cycles -> P_DATA=0xA5, one data_valid pulse, par_err=0, stop_err=0.
  - PARITY_CHECK_EN, PAR_EN=1, PAR_TYP=0: 0x3C with parity bit 0 -> data_valid and P_DATA=0x3C; repeat with parity bit 1 -> par_err pulse, P_DATA stays 0x3C.
  - Stop bit 0 after data 0x81 -> stop_err pulse, no data_valid, busy drops the next cycle.
  - Back-to-back 0x11 then 0x22 with no idle bit -> two data_valid pulses 10 ticks apart, P_DATA 0x11 then 0x22.
  - rst=1 after 4 data bits, then a full 0x5A frame -> all outputs 0 after reset, then P_DATA=0x5A.
  - deser_en=0 after 3 bits, re-enabled with full 0xF0 frame -> no pulse from the aborted frame, then P_DATA=0xF0.
